// File: rtl/booth_disp_pkg.sv
// Shared digit codes, FSM state type and segment decoding for the Booth
// product display path.
package booth_disp_pkg;

  localparam logic [4:0] D_0 = 5'd0, D_1 = 5'd1, D_2 = 5'd2, D_3 = 5'd3;
  localparam logic [4:0] D_4 = 5'd4, D_5 = 5'd5, D_6 = 5'd6, D_7 = 5'd7;
  localparam logic [4:0] D_8 = 5'd8, D_9 = 5'd9, D_A = 5'd10, D_B = 5'd11;
  localparam logic [4:0] D_C = 5'd12, D_D = 5'd13, D_E = 5'd14, D_F = 5'd15;
  localparam logic [4:0] D_BLANK = 5'd16, D_MINUS = 5'd17;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_of(input logic [4:0] code);
    case (code)
      D_0:     seg_of = SEG_ZERO;
      D_1:     seg_of = 7'b1111001;
      D_2:     seg_of = 7'b0100100;
      D_3:     seg_of = 7'b0110000;
      D_4:     seg_of = 7'b0011001;
      D_5:     seg_of = 7'b0010010;
      D_6:     seg_of = 7'b0000010;
      D_7:     seg_of = 7'b1111000;
      D_8:     seg_of = 7'b0000000;
      D_9:     seg_of = 7'b0010000;
      D_A:     seg_of = 7'b0001000;
      D_B:     seg_of = 7'b0000011;
      D_C:     seg_of = 7'b1000110;
      D_D:     seg_of = 7'b0100001;
      D_E:     seg_of = 7'b0000110;
      D_F:     seg_of = 7'b0001110;
      D_MINUS: seg_of = SEG_MINUS;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/booth_result_display_bin2bcd.sv
// Sequential 16-bit double-dabble: 16 iterations, the first folded into load.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);
  logic [35:0] sr;
  logic [4:0]  cnt;
  logic        run;

  function automatic logic [35:0] dabble(input logic [35:0] s);
    logic [35:0] t;
    t = s;
    for (int i = 0; i < 5; i++)
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    return t << 1;
  endfunction

  // The first iteration on an all-zero BCD field is a plain shift, so it is
  // done at load; done then lands one cycle earlier for the controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr  <= {19'b0, bin, 1'b0};
        cnt <= 5'd1;
        run <= 1'b1;
      end else if (run) begin
        sr  <= dabble(sr);
        cnt <= cnt + 5'd1;
        if (cnt == 5'd15) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = run;
  assign bcd  = sr[35:16];
endmodule

// File: rtl/booth_result_display.sv
// Booth product to signed-decimal (or hex fallback) on a 4-digit muxed
// active-low 7-segment display.
module booth_result_display
  import booth_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy
);
  localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

  state_t            state;
  logic [15:0]       src, pend_val, start_val, mag;
  logic              pend, start, done, eng_busy, neg, dp_all, fmt_dp, lead;
  logic [19:0]       bcd;
  logic [3:0][4:0]   disp, fmt;
  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]        idx;

  assign neg = src[15];
  assign idx = cnt[REFRESH_BITS-1 -: 2];

  // A strobe in the same cycle as FORMAT is the newest value and wins over pending.
  always_comb begin
    start_val = (state == IDLE || value_valid) ? value : pend_val;
    start     = (state == IDLE && value_valid) ||
                (state == FORMAT && (value_valid || pend));
    mag       = start_val[15] ? (~start_val + 16'd1) : start_val;
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .busy  (eng_busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    fmt_dp = 1'b0;
    lead   = 1'b1;
    for (int i = 0; i < 4; i++) fmt[i] = {1'b0, src[4*i +: 4]};
    if (!neg && bcd[19:16] == 4'd0) begin
      fmt_dp = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (lead && bcd[4*i +: 4] == 4'd0 && i != 0) fmt[i] = D_BLANK;
        else begin
          fmt[i] = {1'b0, bcd[4*i +: 4]};
          lead   = 1'b0;
        end
      end
    end else if (neg && bcd[19:12] == 8'd0) begin
      fmt_dp = 1'b1;
      fmt[3] = D_BLANK;
      for (int i = 2; i >= 0; i--) begin
        if (lead && bcd[4*i +: 4] == 4'd0 && i != 0) fmt[i] = D_BLANK;
        else begin
          fmt[i] = {1'b0, bcd[4*i +: 4]};
          lead   = 1'b0;
        end
      end
      if (bcd[11:8] != 4'd0)     fmt[3] = D_MINUS;
      else if (bcd[7:4] != 4'd0) fmt[2] = D_MINUS;
      else                       fmt[1] = D_MINUS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
      src      <= '0;
      disp     <= {D_BLANK, D_BLANK, D_BLANK, D_0};
      dp_all   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (value_valid) begin
          src   <= start_val;
          state <= CONV;
          busy  <= 1'b1;
        end
        CONV: begin
          if (value_valid) begin
            pend     <= 1'b1;
            pend_val <= value;
          end
          if (done && !eng_busy) state <= FORMAT;
        end
        FORMAT: begin
          disp   <= fmt;
          dp_all <= fmt_dp;
          pend   <= 1'b0;
          if (start) begin
            src   <= start_val;
            state <= CONV;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // an, seg and dp share one register stage so a digit change never ghosts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      an  <= 4'b1110;
      seg <= SEG_ZERO;
      dp  <= 1'b1;
    end else begin
      cnt <= cnt + CNT_ONE;
      an  <= ~(4'b0001 << idx);
      seg <= seg_of(disp[idx]);
      dp  <= (disp[idx] == D_BLANK) | dp_all;
    end
  end
endmodule

// File: tb/tb_booth_result_display.sv
// Randomized bench for booth_result_display against an arithmetic display model.
module tb_booth_result_display;
  logic        clk = 1'b0, rst_n = 1'b0, value_valid = 1'b0;
  logic [15:0] value = '0;
  logic [6:0]  seg;
  logic        dp, busy;
  logic [3:0]  an;
  int          total = 0, bad = 0;
  logic [3:0][6:0] cs, s5, s9;
  logic [3:0]      cd, d5, d9;
  logic [3:0]      prev;

  booth_result_display #(.REFRESH_BITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .value_valid (value_valid),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [6:0] seg7(input int c);
    case (c)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      15: return 7'b0001110; 17: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected per-digit segments and dp, from the signed value directly.
  task automatic model(input logic [15:0] v, output logic [3:0][6:0] s, output logic [3:0] d);
    int sv, m, nd;
    int pw[4] = '{1, 10, 100, 1000};
    sv = int'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    for (int i = 0; i < 4; i++) begin
      s[i] = seg7(16);
      d[i] = 1'b1;
    end
    if (sv >= 0 && sv <= 9999) begin
      for (int i = 0; i < 4; i++)
        if (i == 0 || m >= pw[i]) s[i] = seg7((m / pw[i]) % 10);
    end else if (sv < 0 && m <= 999) begin
      nd = (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
      for (int i = 0; i < nd; i++) s[i] = seg7((m / pw[i]) % 10);
      s[nd] = seg7(17);
    end else begin
      for (int i = 0; i < 4; i++) begin
        s[i] = seg7(int'(v[4*i +: 4]));
        d[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_disp(input logic [3:0][6:0] s, input logic [3:0] d);
    int idx = 0;
    chk("an_onehot", $countones(~an), 1);
    for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
    chk("seg", seg, s[idx]);
    chk("dp", dp, d[idx]);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Strobe v; busy for 17 samples, old digits through sample 17, new from 18.
  task automatic run_one(input logic [15:0] v);
    logic [3:0][6:0] ns;
    logic [3:0]      nd;
    model(v, ns, nd);
    value = v;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk("busy", busy, k < 17);
      chk_disp(cs, cd);
      step;
    end
    cs = ns;
    cd = nd;
    for (int k = 0; k < 16; k++) begin
      chk("busy_idle", busy, 0);
      chk_disp(cs, cd);
      step;
    end
  endtask

  initial begin
    logic [15:0] dir[10] = '{16'd1234, 16'hFFC8, 16'hFC19, 16'd10000, 16'hFC18,
                             16'h8000, 16'd0, 16'd9999, 16'hFFFF, 16'd7};
    logic [15:0] rv;

    repeat (3) step;
    chk("rst_busy", busy, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_dp", dp, 1);
    rst_n = 1'b1;
    model(16'd0, cs, cd);
    prev = an;
    for (int k = 0; k < 24; k++) begin
      chk_disp(cs, cd);
      if (an != prev) chk("an_order", an, {prev[2:0], prev[3]});
      prev = an;
      step;
    end

    foreach (dir[i]) run_one(dir[i]);
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       rv = 16'($urandom);
        1:       rv = 16'($urandom_range(0, 9999));
        default: rv = 16'(-int'($urandom_range(1, 999)));
      endcase
      run_one(rv);
    end

    // Back-to-back: 7 is overwritten by 9 while the 5 conversion runs.
    model(16'd5, s5, d5);
    model(16'd9, s9, d9);
    value = 16'd5;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int k = 0; k < 51; k++) begin
      chk("busy_pend", busy, k <= 33);
      if (k < 18)      chk_disp(cs, cd);
      else if (k < 35) chk_disp(s5, d5);
      else             chk_disp(s9, d9);
      value_valid = (k == 2 || k == 5);
      if (k == 2) value = 16'd7;
      if (k == 5) value = 16'd9;
      step;
    end
    value_valid = 1'b0;
    cs = s9;
    cd = d9;

    // Reset in the middle of converting 4321.
    value = 16'd4321;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("busy_pre_rst", busy, 1);
      chk_disp(cs, cd);
      step;
    end
    rst_n = 1'b0;
    step;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_an", an, 4'b1110);
    chk("mid_rst_seg", seg, 7'b1000000);
    chk("mid_rst_dp", dp, 1);
    rst_n = 1'b1;
    model(16'd0, cs, cd);
    for (int k = 0; k < 32; k++) begin
      chk("busy_post_rst", busy, 0);
      chk_disp(cs, cd);
      step;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_result_display.md
Name: booth_result_display

Overview:
- Downstream of the Booth multiplier top. Consumes the 16-bit two's-complement product {A[7:0], Q[7:0]} and a one-cycle valid strobe issued when the controller finishes.
- Converts the product to signed decimal with a sequential double-dabble engine.
- Drives the Basys-3 4-digit multiplexed 7-segment display. Segments, decimal points and anodes are all active-low.
- Out-of-range values are shown as raw hex with every decimal point lit.

Parameters:
- REFRESH_BITS, 18, width of the scan counter. The top 2 bits select the digit; 100 MHz / 2^18 ≈ 381 Hz full scan. Benches use 4.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  synchronous, active-low reset
- value  input  16  product, two's complement
- value_valid  input  1  one-cycle strobe; latch value and start conversion
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low; an[0]=rightmost digit
- busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State=IDLE, busy=0, pending flag cleared, scan counter=0.
  - Display registers set to blank,blank,blank,'0' with all dp off.
  - Outputs: an=4'b1110, seg=7'b1000000 ('0'), dp=1.
  - Reset mid-conversion aborts the conversion; the display shows '0'.
- FSM states: IDLE, CONV, FORMAT.
  - IDLE: on value_valid, capture value into src and go to CONV. Capture |value| into the shift register; neg=value[15]. Magnitude of 0x8000 is 32768, held in 16 bits unsigned.
  - CONV: exactly 16 cycles. Each cycle: add 3 to every BCD nibble ≥5, then shift left 1. There are 5 BCD nibbles (20 bits). The 5-bit iteration counter reaches 16, then go to FORMAT.
  - FORMAT: 1 cycle. Write the four display digit registers, then go to IDLE.
- busy=1 in CONV and FORMAT.
- Latency: value_valid at cycle 0 → new digits visible on seg from cycle 18.
- Formatting rules:
  - neg=0 and magnitude ≤ 9999: decimal, with leading zeros blanked. Value 0 shows a single '0' in digit 0.
  - neg=1 and magnitude ≤ 999: '-' (seg=7'b0111111) placed immediately left of the most significant nonzero digit. Remaining positions blank.
  - Otherwise: show src as 4 hex digits (0-9, A, b, C, d, E, F) with dp=0 on all digits.
- value_valid while busy:
  - Capture the value into a one-deep pending register; a later strobe overwrites an earlier one (last wins).
  - When FORMAT completes with pending set, go directly to CONV on the next cycle with the pending value.
  - The display is never torn: the old digits are held until FORMAT.
- Scan:
  - The scan counter free-runs and wraps.
  - Digit index = cnt[REFRESH_BITS-1:REFRESH_BITS-2]; index 0 is the rightmost digit.
  - Exactly one an bit is low at any time.
  - seg and dp are registered together with an, so there is no ghosting across a digit change.
- Blank digit: seg=7'b1111111, dp=1.

Decomposition:
- Package booth_disp_pkg:
  - 5-bit digit-code constants: D_0..D_F = 0..15, D_BLANK = 16, D_MINUS = 17.
  - Function mapping code → active-low 7-bit segment pattern.
  - Constant SEG_ZERO.
- Sub-module bin2bcd_seq: 16-bit double-dabble.
  - Ports: clk, rst_n, start, bin, busy, done, bcd[19:0].
  - The top keeps the FSM/formatting and the scan mux.

Test Plan (REFRESH_BITS=4, sample all four digits per scan):
- Release reset with no strobe → an cycles 1110,1101,1011,0111; seg '0' on digit 0, blanks elsewhere, dp=1 throughout.
- value=16'd1234 strobe → busy high for exactly 17 cycles; from cycle 18 the digits read "1234" and dp=1.
- value=16'hFFC8 (-56) → digits " -56": digit 2 shows seg=7'b0111111, digit 3 blank. value=16'hFC19 (-999) → "-999".
- value=16'd10000 (0x2710) → hex "2710", dp=0 on all digits. value=16'hFC18 (-1000) → "FC18", all dp lit. value=16'h8000 → "8000", all dp lit.
- Strobe 16'd5, then 16'd7 and 16'd9 during busy → display shows "5" first, then "9"; "7" is never displayed. busy stays high continuously across both conversions except for no gap.
- Pull rst_n low at CONV cycle 8 of value 16'd4321 → next cycle busy=0 and an=1110/seg='0'; "4321" never appears.
